// File: rtl/fft_reorder.sv
// Reorders bit-reversed FFT output frames into natural order using two ping-pong frame banks.
// Optional start-of-frame output do_sof is built when FFT_REORDER_SOF_EN is defined.
module fft_reorder #(
  parameter int unsigned N     = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
`ifdef FFT_REORDER_SOF_EN
  output logic [WIDTH-1:0] do_im,
  output logic             do_sof
`else
  output logic [WIDTH-1:0] do_im
`endif
);

  localparam int unsigned AW = $clog2(N);
  localparam logic [AW-1:0] LastAddr = AW'(N - 1);

  localparam logic StIdle = 1'b0;
  localparam logic StRead = 1'b1;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem_q [2][N];

  logic [AW-1:0]      wcnt_q, wcnt_d;
  logic [AW-1:0]      rcnt_q, rcnt_d;
  logic               wbank_q, wbank_d;
  logic               rbank_q, rbank_d;
  logic [1:0]         full_q, full_d;
  logic               state_q, state_d;
  logic               do_en_q;
  logic [2*WIDTH-1:0] rdata_q;
  logic               rd_active;

  assign rd_active = (state_q == StRead);

  always_comb begin
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    full_d  = full_q;
    state_d = state_q;

    if (di_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LastAddr) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    case (state_q)
      StIdle: begin
        if (|full_q) begin
          state_d = StRead;
          // Prefer the bank after the one last read so frames stay in arrival order.
          rbank_d = full_q[~rbank_q] ? ~rbank_q : rbank_q;
          rcnt_d  = '0;
        end
      end
      StRead: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LastAddr) begin
          full_d[rbank_q] = 1'b0;
          if (full_q[~rbank_q]) begin
            rbank_d = ~rbank_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (di_en) begin
      mem_q[wbank_q][bitrev(wcnt_q)] <= {di_re, di_im};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= '0;
      state_q <= StIdle;
      do_en_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      state_q <= state_d;
      do_en_q <= rd_active;
      if (rd_active) begin
        rdata_q <= mem_q[rbank_q][rcnt_q];
      end
    end
  end

  assign do_en = do_en_q;
  assign do_re = rdata_q[2*WIDTH-1:WIDTH];
  assign do_im = rdata_q[WIDTH-1:0];

`ifdef FFT_REORDER_SOF_EN
  logic sof_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sof_q <= 1'b0;
    end else begin
      sof_q <= rd_active && (rcnt_q == '0);
    end
  end

  assign do_sof = sof_q;
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: bit-reversed frames in, natural-order frames out.
// Builds with N=16 and checks do_sof when FFT_REORDER_SOF_EN is defined.
module tb_fft_reorder;

`ifdef FFT_REORDER_SOF_EN
  localparam int N = 16;
`else
  localparam int N = 1024;
`endif
  localparam int W    = 32;
  localparam int AW   = $clog2(N);
  localparam int Part = (N > 1000) ? 500 : N / 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         di_en = 1'b0;
  logic [W-1:0] di_re = '0;
  logic [W-1:0] di_im = '0;
  logic         do_en;
  logic [W-1:0] do_re;
  logic [W-1:0] do_im;
`ifdef FFT_REORDER_SOF_EN
  logic         do_sof;
`endif

  fft_reorder #(
    .N     (N),
    .WIDTH (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
`ifdef FFT_REORDER_SOF_EN
    .do_im (do_im),
    .do_sof(do_sof)
`else
    .do_im (do_im)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int out_idx = 0;
  logic [2*W-1:0] last_out = '0;
  logic [2*W-1:0] exp_q[$];
  int             edge_q[$];

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < AW; b++) begin
      if (v[b]) r |= 1 << (AW - 1 - b);
    end
    return r;
  endfunction

  // Output monitor: pops the expected stream, checks latency at each frame start and hold when idle.
  always @(negedge clock) begin
    if (reset) begin
      out_idx  = 0;
      last_out = '0;
    end else if (do_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_do_en", 64'(do_en), 64'd0);
      end else begin
        if (out_idx == 0) check("latency", 64'(edge_cnt - edge_q.pop_front()), 64'd2);
        check("data", {do_re, do_im}, exp_q.pop_front());
      end
`ifdef FFT_REORDER_SOF_EN
      check("sof", 64'(do_sof), 64'(out_idx == 0));
`endif
      last_out = {do_re, do_im};
      out_idx  = (out_idx + 1) % N;
    end else begin
      if (out_idx != 0) check("burst_gap", 64'(do_en), 64'd1);
      check("hold", {do_re, do_im}, last_out);
`ifdef FFT_REORDER_SOF_EN
      check("sof_idle", 64'(do_sof), 64'd0);
`endif
    end
  end

  task automatic drive_frame(input int off, input bit gappy, input int nsamp);
    logic [2*W-1:0] e;
    for (int i = 0; i < nsamp; i++) begin
      if (gappy) begin
        while ($urandom_range(0, 1) == 0) begin
          di_en = 1'b0;
          @(posedge clock);
          #1;
        end
      end
      di_en = 1'b1;
      di_re = W'(bitrev(i) + off);
      di_im = W'(N - 1 - bitrev(i) + off);
      @(posedge clock);
      #1;
    end
    di_en = 1'b0;
    if (nsamp == N) begin
      edge_q.push_back(edge_cnt);
      for (int k = 0; k < N; k++) begin
        e = {W'(k + off), W'(N - 1 - k + off)};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 4 * N && exp_q.size() != 0; c++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    edge_q.delete();
    check("rst_do_en", 64'(do_en), 64'd0);
    check("rst_do_re", 64'(do_re), 64'd0);
    check("rst_do_im", 64'(do_im), 64'd0);
`ifdef FFT_REORDER_SOF_EN
    check("rst_do_sof", 64'(do_sof), 64'd0);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    pulse_reset();
    repeat (5) @(posedge clock);
    #1;

    drive_frame(0, 1'b0, N);
    wait_drain("drain_single");

    for (int f = 0; f < 3; f++) drive_frame(4096 * f, 1'b0, N);
    wait_drain("drain_b2b");

    for (int f = 0; f < 2; f++) drive_frame(4096 * (f + 3), 1'b1, N);
    wait_drain("drain_gappy");

    drive_frame(32'h5000, 1'b0, Part);
    pulse_reset();
    repeat (3) @(posedge clock);
    #1;
    drive_frame(32'h6000, 1'b0, N);
    wait_drain("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
